// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS serial-port engine.
package dds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    UPD_WAIT,
    UPD,
    DONE
  } state_t;

  localparam int INSTR_BITS        = 8;
  localparam int READ_BIT          = 7;
  localparam int ADDR_BITS         = 5;
  localparam int DEFAULT_DATA_BITS = 32;

  // Builds an instruction byte: read flag, two pass-through bits, register address.
  function automatic logic [INSTR_BITS-1:0] make_order(input logic rd,
                                                       input logic [1:0] mid,
                                                       input logic [ADDR_BITS-1:0] addr);
    return {rd, mid, addr};
  endfunction

endpackage

// File: rtl/dds_serial_port_if.sv
// Request side of the DDS serial-port engine (sequencer <-> engine).
interface dds_serial_port_if #(
  parameter int DATA_BITS = dds_pkg::DEFAULT_DATA_BITS
);
  // Strobe handshake: the master pulses start for one cycle with order/data
  // valid; the engine only samples it while idle and later pulses done for one
  // cycle, with rd_data holding the most recent read payload from then on.
  logic                 start;
  logic [7:0]           order;
  logic [DATA_BITS-1:0] data;
  logic [DATA_BITS-1:0] rd_data;
  logic                 done;

  modport master (output start, order, data, input rd_data, done);
  modport slave  (input start, order, data, output rd_data, done);
endinterface

// File: rtl/dds_serial_port_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic ff1, ff2, ff3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1  <= 1'b0;
      ff2  <= 1'b0;
      ff3  <= 1'b0;
      rise <= 1'b0;
    end else begin
      ff1  <= din;
      ff2  <= ff1;
      ff3  <= ff2;
      rise <= ff2 & ~ff3;
    end
  end
endmodule

// File: rtl/dds_serial_port.sv
// SPI engine for an AD9910-class DDS: shifts {order, data} MSB first, captures
// read data, pulses IO_UPDATE after writes. DDS_IOUPD_SYNC_EN aligns IO_UPDATE to SYNC_CLK.
module dds_serial_port
  import dds_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int IOUPD_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  dds_serial_port_if.slave   bus,
  output logic               SYNCIO,
  output logic               SDIO,
  input  logic               SDO,
  output logic               SCLK,
  output logic               CS,
  output logic               IO_UPDATE,
  input  logic               SYNC_CLK,
  output state_t             dbg_state
);
  localparam int TOTAL_BITS = INSTR_BITS + DATA_BITS;
  localparam int BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam int DIV_W      = $clog2(CLK_DIV + 1);
  localparam int UPD_W      = $clog2(IOUPD_LEN + 1);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(TOTAL_BITS - 1);
  localparam logic [BIT_W-1:0] FIRST_DATA = BIT_W'(INSTR_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [UPD_W-1:0] UPD_LAST   = UPD_W'(IOUPD_LEN - 1);

  state_t                state;
  logic [TOTAL_BITS-2:0] shift_q;  // bits still to send after the one on SDIO
  logic [DATA_BITS-1:0]  cap_q;
  logic                  rd_flag;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;  // falling edges seen so far
  logic [UPD_W-1:0]      upd_cnt;

  assign dbg_state = state;

`ifdef DDS_IOUPD_SYNC_EN
  logic sync_rise;
  sync_edge u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (SYNC_CLK),
    .rise (sync_rise)
  );
`else
  logic unused_sync_clk;
  assign unused_sync_clk = SYNC_CLK;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      CS          <= 1'b1;
      SCLK        <= 1'b0;
      SDIO        <= 1'b0;
      IO_UPDATE   <= 1'b0;
      SYNCIO      <= 1'b1;
      bus.done    <= 1'b0;
      bus.rd_data <= '0;
      shift_q     <= '0;
      cap_q       <= '0;
      rd_flag     <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      upd_cnt     <= '0;
    end else begin
      SYNCIO   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q <= {bus.order[INSTR_BITS-2:0], bus.data};
            rd_flag <= bus.order[READ_BIT];
            SDIO    <= bus.order[INSTR_BITS-1];
            CS      <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
              // The first INSTR_BITS clocks carry the instruction; DDS read data follows.
              if (rd_flag && bit_cnt >= FIRST_DATA)
                cap_q <= {cap_q[DATA_BITS-2:0], SDO};
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                CS   <= 1'b1;
                SDIO <= 1'b0;
                if (rd_flag) begin
                  state <= DONE;
                end else begin
`ifdef DDS_IOUPD_SYNC_EN
                  state <= UPD_WAIT;
`else
                  IO_UPDATE <= 1'b1;
                  upd_cnt   <= '0;
                  state     <= UPD;
`endif
                end
              end else begin
                SDIO    <= shift_q[TOTAL_BITS-2];
                shift_q <= {shift_q[TOTAL_BITS-3:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        UPD_WAIT: begin
`ifdef DDS_IOUPD_SYNC_EN
          if (sync_rise) begin
            IO_UPDATE <= 1'b1;
            upd_cnt   <= '0;
            state     <= UPD;
          end
`else
          state <= IDLE;
`endif
        end
        UPD: begin
          if (upd_cnt == UPD_LAST) begin
            IO_UPDATE <= 1'b0;
            state     <= DONE;
          end else begin
            upd_cnt <= upd_cnt + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          if (rd_flag)
            bus.rd_data <= cap_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
